// File: rtl/seg7_display_arbiter_pkg.sv
// Shared definitions for the 7-segment display arbiter: FSM states, operator
// codes, requester indices and small index helpers.
package seg7_display_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [2:0] OP_T = 3'd0;
    localparam logic [2:0] OP_A = 3'd1;
    localparam logic [2:0] OP_B = 3'd2;
    localparam logic [2:0] OP_C = 3'd3;

    localparam logic [1:0] REQ_ERR    = 2'd0;
    localparam logic [1:0] REQ_OP     = 2'd1;
    localparam logic [1:0] REQ_RESULT = 2'd2;

    function automatic logic [1:0] onehot_to_idx(input logic [2:0] onehot);
        logic [1:0] idx;
        case (onehot)
            3'b010:  idx = 2'd1;
            3'b100:  idx = 2'd2;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Round-robin pointer: the requester after the last winner is checked first.
    function automatic logic [1:0] next_ptr(input logic [1:0] winner);
        logic [1:0] ptr;
        case (winner)
            2'd0:    ptr = 2'd1;
            2'd1:    ptr = 2'd2;
            default: ptr = 2'd0;
        endcase
        return ptr;
    endfunction

endpackage

// File: rtl/seg7_display_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker: first active request at or after ptr.
module rr_pick3 (
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] grant
);

    // Priority search rotated by the pointer.
    always_comb begin
        grant = 3'b000;
        case (ptr)
            2'd1: begin
                if (req[1])      grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else             grant = 3'b000;
            end
            2'd2: begin
                if (req[2])      grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else             grant = 3'b000;
            end
            default: begin
                if (req[0])      grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else             grant = 3'b000;
            end
        endcase
    end

endmodule

// File: rtl/seg7_display_arbiter.sv
// Shares one 7-segment driver between three requesters: round-robin grant,
// fixed display window with optional blink, forced blank gap between windows.
module seg7_display_arbiter
    import seg7_display_arbiter_pkg::*;
#(
    parameter int HOLD_CYCLES = 100_000_000,
    parameter int GAP_CYCLES  = 1_000,
    parameter int BLINK_HALF  = 25_000_000,
    parameter int CNT_W       = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic [2:0]  i_req,
    input  logic [2:0]  i_mode,
    input  logic [8:0]  i_op_code,
    input  logic [11:0] i_digit,
    input  logic [2:0]  i_blink,
    output logic [2:0]  o_grant,
    output logic [2:0]  o_done,
    output logic        o_busy,
    output logic        o_en,
    output logic        o_disp_mode,
    output logic [2:0]  o_op_code,
    output logic [3:0]  o_digit_val
);

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [CNT_W-1:0] blink_cnt_r, blink_cnt_s;
    logic             phase_r, phase_s;
    logic             blink_en_r, blink_en_s;
    logic [1:0]       ptr_r, ptr_s;
    logic [2:0]       grant_r, grant_s;
    logic [2:0]       done_r, done_s;
    logic             busy_r, busy_s;
    logic             en_r, en_s;
    logic             mode_r, mode_s;
    logic [2:0]       op_r, op_s;
    logic [3:0]       digit_r, digit_s;

    logic [2:0]       pick_s;
    logic [1:0]       pick_idx_s;
    logic             go_gap_s;

    rr_pick3 u_pick (
        .req   (i_req),
        .ptr   (ptr_r),
        .grant (pick_s)
    );

    assign pick_idx_s = onehot_to_idx(pick_s);

    // Next-state, counter, payload and output computation.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        blink_cnt_s = blink_cnt_r;
        phase_s     = phase_r;
        blink_en_s  = blink_en_r;
        ptr_s       = ptr_r;
        grant_s     = grant_r;
        done_s      = 3'b000;
        busy_s      = busy_r;
        en_s        = en_r;
        mode_s      = mode_r;
        op_s        = op_r;
        digit_s     = digit_r;
        go_gap_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (i_clear) begin
                    grant_s = 3'b000;
                    en_s    = 1'b0;
                end else if (|i_req) begin
                    state_s     = ST_SHOW;
                    ptr_s       = next_ptr(pick_idx_s);
                    grant_s     = pick_s;
                    en_s        = 1'b1;
                    busy_s      = 1'b1;
                    cnt_s       = '0;
                    blink_cnt_s = '0;
                    phase_s     = 1'b1;
                    for (int k = 0; k < 3; k++) begin
                        if (pick_s[k]) begin
                            mode_s     = i_mode[k];
                            op_s       = i_op_code[3*k +: 3];
                            digit_s    = i_digit[4*k +: 4];
                            blink_en_s = i_blink[k];
                        end else begin
                            mode_s     = mode_s;
                        end
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHOW: begin
                // Clear and withdrawal both abort silently; completion pulses done.
                if (i_clear || !(|(i_req & grant_r))) begin
                    go_gap_s = 1'b1;
                end else if (cnt_r == HOLD_LAST) begin
                    go_gap_s = 1'b1;
                    done_s   = grant_r;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                    if (blink_cnt_r == BLINK_LAST) begin
                        blink_cnt_s = '0;
                        phase_s     = ~phase_r;
                    end else begin
                        blink_cnt_s = blink_cnt_r + CNT_W'(1);
                    end
                    en_s = blink_en_r ? phase_s : 1'b1;
                end
            end
            ST_GAP: begin
                if (i_clear) begin
                    cnt_s = '0;
                end else if (cnt_r == GAP_LAST) begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                    cnt_s   = '0;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                grant_s = 3'b000;
                busy_s  = 1'b0;
                en_s    = 1'b0;
                mode_s  = 1'b0;
                op_s    = 3'b000;
                digit_s = 4'b0000;
                cnt_s   = '0;
            end
        endcase

        if (go_gap_s) begin
            state_s     = ST_GAP;
            grant_s     = 3'b000;
            en_s        = 1'b0;
            busy_s      = 1'b1;
            mode_s      = 1'b0;
            op_s        = 3'b000;
            digit_s     = 4'b0000;
            cnt_s       = '0;
            blink_cnt_s = '0;
        end else begin
            blink_cnt_s = blink_cnt_s;
        end
    end

    // State, counter, payload and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            blink_cnt_r <= '0;
            phase_r     <= 1'b0;
            blink_en_r  <= 1'b0;
            ptr_r       <= 2'd0;
            grant_r     <= 3'b000;
            done_r      <= 3'b000;
            busy_r      <= 1'b0;
            en_r        <= 1'b0;
            mode_r      <= 1'b0;
            op_r        <= 3'b000;
            digit_r     <= 4'b0000;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            blink_cnt_r <= blink_cnt_s;
            phase_r     <= phase_s;
            blink_en_r  <= blink_en_s;
            ptr_r       <= ptr_s;
            grant_r     <= grant_s;
            done_r      <= done_s;
            busy_r      <= busy_s;
            en_r        <= en_s;
            mode_r      <= mode_s;
            op_r        <= op_s;
            digit_r     <= digit_s;
        end
    end

    assign o_grant     = grant_r;
    assign o_done      = done_r;
    assign o_busy      = busy_r;
    assign o_en        = en_r;
    assign o_disp_mode = mode_r;
    assign o_op_code   = op_r;
    assign o_digit_val = digit_r;

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Directed bench for seg7_display_arbiter with short windows (hold 20, gap 3, blink 4).
module tb_seg7_display_arbiter;

    logic        clk;
    logic        rst;
    logic        i_clear;
    logic [2:0]  i_req;
    logic [2:0]  i_mode;
    logic [8:0]  i_op_code;
    logic [11:0] i_digit;
    logic [2:0]  i_blink;
    logic [2:0]  o_grant;
    logic [2:0]  o_done;
    logic        o_busy;
    logic        o_en;
    logic        o_disp_mode;
    logic [2:0]  o_op_code;
    logic [3:0]  o_digit_val;

    int checks = 0;
    int errors = 0;

    seg7_display_arbiter #(
        .HOLD_CYCLES (20),
        .GAP_CYCLES  (3),
        .BLINK_HALF  (4),
        .CNT_W       (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (i_clear),
        .i_req       (i_req),
        .i_mode      (i_mode),
        .i_op_code   (i_op_code),
        .i_digit     (i_digit),
        .i_blink     (i_blink),
        .o_grant     (o_grant),
        .o_done      (o_done),
        .o_busy      (o_busy),
        .o_en        (o_en),
        .o_disp_mode (o_disp_mode),
        .o_op_code   (o_op_code),
        .o_digit_val (o_digit_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, {29'd0, o_grant}, 32'd0);
        chk({tag, "_done"},  {29'd0, o_done},  32'd0);
        chk({tag, "_busy"},  {31'd0, o_busy},  32'd0);
        chk({tag, "_en"},    {31'd0, o_en},    32'd0);
        chk({tag, "_mode"},  {31'd0, o_disp_mode}, 32'd0);
        chk({tag, "_op"},    {29'd0, o_op_code},   32'd0);
        chk({tag, "_digit"}, {28'd0, o_digit_val}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        i_clear   = 1'b0;
        i_req     = 3'b000;
        i_mode    = 3'b000;
        i_op_code = 9'd0;
        i_digit   = 12'd0;
        i_blink   = 3'b000;

        // Reset state
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();
        chk("idle_busy", {31'd0, o_busy}, 32'd0);

        // Single request from requester 1, operator 2
        i_req     = 3'b010;
        i_op_code = 9'b000_010_000;
        tick();
        chk("t1_grant", {29'd0, o_grant}, 32'h2);
        chk("t1_en",    {31'd0, o_en},    32'd1);
        chk("t1_op",    {29'd0, o_op_code}, 32'd2);
        chk("t1_busy",  {31'd0, o_busy},  32'd1);
        for (int i = 1; i < 20; i++) begin
            tick();
            chk("t1_hold_en",   {31'd0, o_en},      32'd1);
            chk("t1_hold_op",   {29'd0, o_op_code}, 32'd2);
            chk("t1_hold_done", {29'd0, o_done},    32'd0);
        end
        tick();
        chk("t1_done",   {29'd0, o_done},  32'h2);
        chk("t1_ungrant",{29'd0, o_grant}, 32'd0);
        chk("t1_gap_en", {31'd0, o_en},    32'd0);
        chk("t1_gap_op", {29'd0, o_op_code}, 32'd0);
        i_req = 3'b000;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t1_gap_busy", {31'd0, o_busy}, 32'd1);
            chk("t1_gap_done", {29'd0, o_done}, 32'd0);
            chk("t1_gap_en2",  {31'd0, o_en},   32'd0);
        end
        tick();
        chk("t1_idle_busy", {31'd0, o_busy}, 32'd0);

        // All three requesting continuously: order 0,1,2,0
        do_reset();
        i_req     = 3'b111;
        i_op_code = 9'd0;
        for (int w = 0; w < 4; w++) begin
            logic [2:0] exp_g;
            exp_g = (w == 1) ? 3'b010 : ((w == 2) ? 3'b100 : 3'b001);
            tick();
            chk("rr_grant", {29'd0, o_grant}, {29'd0, exp_g});
            for (int i = 1; i < 20; i++) begin
                tick();
                chk("rr_hold", {29'd0, o_grant}, {29'd0, exp_g});
            end
            tick();
            chk("rr_done", {29'd0, o_done}, {29'd0, exp_g});
            for (int i = 0; i < 2; i++) begin
                tick();
                chk("rr_gap", {30'd0, o_busy, o_en}, 32'd2);
            end
            tick();
            chk("rr_idle", {30'd0, o_busy, o_en}, 32'd0);
        end

        // Requester 2 digit 7 withdraws at show cycle 5; payload changes ignored
        do_reset();
        i_req   = 3'b100;
        i_mode  = 3'b100;
        i_digit = 12'h700;
        tick();
        chk("t3_grant", {29'd0, o_grant},     32'h4);
        chk("t3_mode",  {31'd0, o_disp_mode}, 32'd1);
        chk("t3_digit", {28'd0, o_digit_val}, 32'd7);
        i_digit = 12'h300;
        i_mode  = 3'b000;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("t3_latched", {28'd0, o_digit_val}, 32'd7);
        end
        i_req = 3'b000;
        tick();
        chk("t3_abort_en",    {31'd0, o_en},        32'd0);
        chk("t3_abort_done",  {29'd0, o_done},      32'd0);
        chk("t3_abort_grant", {29'd0, o_grant},     32'd0);
        chk("t3_abort_busy",  {31'd0, o_busy},      32'd1);
        chk("t3_abort_digit", {28'd0, o_digit_val}, 32'd0);
        tick();
        tick();
        chk("t3_gap_done", {29'd0, o_done}, 32'd0);
        tick();
        chk("t3_idle", {31'd0, o_busy}, 32'd0);

        // Blink on requester 0: 4 on, 4 off across the window
        do_reset();
        i_mode  = 3'b000;
        i_digit = 12'd0;
        i_blink = 3'b001;
        i_req   = 3'b001;
        tick();
        chk("blink_c0", {31'd0, o_en}, 32'd1);
        for (int c = 1; c < 20; c++) begin
            tick();
            chk("blink_en", {31'd0, o_en}, {31'd0, ((c / 4) % 2) == 0});
        end
        tick();
        chk("blink_done", {29'd0, o_done}, 32'h1);
        i_blink = 3'b000;

        // Asynchronous reset at show cycle 10, then fresh grant to 0
        do_reset();
        i_req = 3'b001;
        tick();
        chk("t5_grant", {29'd0, o_grant}, 32'h1);
        for (int i = 1; i <= 10; i++) tick();
        rst = 1'b1;
        #1;
        chk_all_zero("t5_async");
        tick();
        chk_all_zero("t5_held");
        rst = 1'b0;
        tick();
        chk("t5_regrant", {29'd0, o_grant}, 32'h1);
        chk("t5_en",      {31'd0, o_en},    32'd1);

        // Clear on the completion cycle beats done
        for (int i = 1; i <= 19; i++) tick();
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        chk("t6_done",  {29'd0, o_done},  32'd0);
        chk("t6_grant", {29'd0, o_grant}, 32'd0);
        chk("t6_en",    {31'd0, o_en},    32'd0);
        chk("t6_busy",  {31'd0, o_busy},  32'd1);
        tick();
        tick();
        chk("t6_gap_done", {29'd0, o_done}, 32'd0);
        tick();
        chk("t6_idle", {31'd0, o_busy}, 32'd0);

        // Clear while idle blocks the grant for that edge
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        chk("idle_clr_grant", {29'd0, o_grant}, 32'd0);
        chk("idle_clr_busy",  {31'd0, o_busy},  32'd0);
        tick();
        chk("post_clr_grant", {29'd0, o_grant}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
